// File: rtl/sata_phy_pkg.sv
// Shared constants, TX state encoding and comma-lane decode for the SATA PHY adapter.
package sata_phy_pkg;

   localparam logic [31:0] SATA_ALIGN   = 32'h7B4A4ABC;
   localparam logic [3:0]  SATA_ALIGN_K = 4'b0001;

   typedef enum logic [1:0] {
      LINKDN = 2'd0,
      ALN1   = 2'd1,
      ALN2   = 2'd2,
      DATA   = 2'd3
   } tx_state_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] lane;
   } comma_t;

   // Only a one-hot charisk identifies a comma lane; anything else is ignored.
   function automatic comma_t comma_lane(input logic [3:0] k);
      comma_t r;
      r.valid = 1'b1;
      r.lane  = 2'd0;
      case (k)
         4'b0001: r.lane = 2'd0;
         4'b0010: r.lane = 2'd1;
         4'b0100: r.lane = 2'd2;
         4'b1000: r.lane = 2'd3;
         default: r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sata_phy_lane.sv
// One SATA PHY channel: TX ALIGN insertion FSM and RX byte-lane aligner.
// Optional per-channel statistics when SATA_PHY_IF_STATS_EN is defined.
//
// state  | meaning
// LINKDN | link down, send ALIGN continuously, no pop
// ALN1   | first ALIGN of the periodic pair
// ALN2   | second ALIGN of the periodic pair
// DATA   | pass link-layer dwords, pop every cycle
module sata_phy_lane
   import sata_phy_pkg::*;
#(
   parameter int C_ALIGN_INTERVAL = 256
) (
   input  logic        phyclk,
   input  logic        phyreset_n,
   input  logic        link_up,
   input  logic [31:0] tx_data,
   input  logic        tx_isk,
   output logic        tx_pop,
   output logic [31:0] gtx_txdata,
   output logic [3:0]  gtx_txcharisk,
   input  logic [31:0] gtx_rxdata,
   input  logic [3:0]  gtx_rxcharisk,
   output logic [31:0] rx_data,
   output logic        rx_isk,
   output logic        rx_valid,
   output logic        rx_aligned
`ifdef SATA_PHY_IF_STATS_EN
   ,
   output logic [15:0] stat_align_drop,
   output logic [7:0]  stat_relock
`endif
);

   localparam int              DW        = $clog2(C_ALIGN_INTERVAL);
   localparam logic [DW-1:0]   DCNT_LAST = DW'(C_ALIGN_INTERVAL - 3);

   tx_state_t     state, state_nxt;
   logic [DW-1:0] dcnt, dcnt_nxt;
   logic [31:0]   tx_word;
   logic [3:0]    tx_k;

   always_ff @(posedge phyclk or negedge phyreset_n) begin
      if (!phyreset_n) begin
         state <= LINKDN;
         dcnt  <= '0;
      end else begin
         state <= state_nxt;
         dcnt  <= dcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      dcnt_nxt  = '0;
      case (state)
         LINKDN: if (link_up) state_nxt = ALN1;
         ALN1:   state_nxt = ALN2;
         ALN2:   state_nxt = DATA;
         DATA: begin
            if (dcnt == DCNT_LAST) state_nxt = ALN1;
            else                   dcnt_nxt  = dcnt + 1'b1;
         end
         default: state_nxt = LINKDN;
      endcase
      // Link loss overrides everything, including the DATA->ALN1 wrap.
      if (!link_up) begin
         state_nxt = LINKDN;
         dcnt_nxt  = '0;
      end
   end

   always_comb begin
      tx_pop  = (state == DATA);
      tx_word = SATA_ALIGN;
      tx_k    = SATA_ALIGN_K;
      if (state == DATA) begin
         tx_word = tx_data;
         tx_k    = {3'b000, tx_isk};
      end
   end

   always_ff @(posedge phyclk or negedge phyreset_n) begin
      if (!phyreset_n) begin
         gtx_txdata    <= SATA_ALIGN;
         gtx_txcharisk <= SATA_ALIGN_K;
      end else begin
         gtx_txdata    <= tx_word;
         gtx_txcharisk <= tx_k;
      end
   end

   logic [31:0] prev_data, aln_data;
   logic [3:0]  prev_k, aln_k;
   logic [1:0]  off;
   logic        off_upd, is_align, aln_seen;
   comma_t      cl;

   assign cl       = comma_lane(gtx_rxcharisk);
   assign off_upd  = cl.valid && (cl.lane != off);
   assign is_align = (aln_data == SATA_ALIGN) && (aln_k == SATA_ALIGN_K);

   // Lane p places the comma byte of the previous word at byte 0 of the output.
   always_comb begin
      aln_data = prev_data;
      aln_k    = prev_k;
      case (off)
         2'd1: begin
            aln_data = {gtx_rxdata[7:0], prev_data[31:8]};
            aln_k    = {gtx_rxcharisk[0], prev_k[3:1]};
         end
         2'd2: begin
            aln_data = {gtx_rxdata[15:0], prev_data[31:16]};
            aln_k    = {gtx_rxcharisk[1:0], prev_k[3:2]};
         end
         2'd3: begin
            aln_data = {gtx_rxdata[23:0], prev_data[31:24]};
            aln_k    = {gtx_rxcharisk[2:0], prev_k[3]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge phyclk or negedge phyreset_n) begin
      if (!phyreset_n) begin
         prev_data  <= '0;
         prev_k     <= '0;
         off        <= '0;
         aln_seen   <= 1'b0;
         rx_aligned <= 1'b0;
         rx_data    <= '0;
         rx_isk     <= 1'b0;
         rx_valid   <= 1'b0;
      end else begin
         prev_data <= gtx_rxdata;
         prev_k    <= gtx_rxcharisk;
         if (off_upd) off <= cl.lane;
         if (!link_up || off_upd) begin
            aln_seen   <= 1'b0;
            rx_aligned <= 1'b0;
         end else if (is_align) begin
            aln_seen <= 1'b1;
            if (aln_seen) rx_aligned <= 1'b1;
         end else begin
            aln_seen <= 1'b0;
         end
         rx_data  <= aln_data;
         rx_isk   <= aln_k[0];
         rx_valid <= link_up && !is_align && rx_aligned;
      end
   end

`ifdef SATA_PHY_IF_STATS_EN
   logic link_q;

   always_ff @(posedge phyclk or negedge phyreset_n) begin
      if (!phyreset_n) begin
         link_q          <= 1'b0;
         stat_align_drop <= '0;
         stat_relock     <= '0;
      end else begin
         link_q <= link_up;
         if (link_up && !link_q) begin
            stat_align_drop <= '0;
            stat_relock     <= '0;
         end else begin
            if (is_align && (stat_align_drop != 16'hFFFF))
               stat_align_drop <= stat_align_drop + 1'b1;
            if (off_upd && (stat_relock != 8'hFF))
               stat_relock <= stat_relock + 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/sata_phy_if_mc.sv
// Multi-channel SATA PHY interface adapter: one sata_phy_lane per channel on sliced buses.
// Define SATA_PHY_IF_STATS_EN to expose per-channel ALIGN-drop and relock counters.
module sata_phy_if_mc
   import sata_phy_pkg::*;
#(
   parameter int C_NUM_CHAN       = 2,
   parameter int C_ALIGN_INTERVAL = 256
) (
   input  logic                    phyclk,
   input  logic                    phyreset_n,
   input  logic [C_NUM_CHAN-1:0]   link_up,
   input  logic [C_NUM_CHAN*32-1:0] tx_data,
   input  logic [C_NUM_CHAN-1:0]   tx_isk,
   output logic [C_NUM_CHAN-1:0]   tx_pop,
   output logic [C_NUM_CHAN*32-1:0] gtx_txdata,
   output logic [C_NUM_CHAN*4-1:0] gtx_txcharisk,
   input  logic [C_NUM_CHAN*32-1:0] gtx_rxdata,
   input  logic [C_NUM_CHAN*4-1:0] gtx_rxcharisk,
   output logic [C_NUM_CHAN*32-1:0] rx_data,
   output logic [C_NUM_CHAN-1:0]   rx_isk,
   output logic [C_NUM_CHAN-1:0]   rx_valid,
   output logic [C_NUM_CHAN-1:0]   rx_aligned
`ifdef SATA_PHY_IF_STATS_EN
   ,
   output logic [C_NUM_CHAN*16-1:0] stat_align_drop,
   output logic [C_NUM_CHAN*8-1:0]  stat_relock
`endif
);

   for (genvar c = 0; c < C_NUM_CHAN; c++) begin : g_chan
      sata_phy_lane #(
         .C_ALIGN_INTERVAL (C_ALIGN_INTERVAL)
      ) u_lane (
         .phyclk          (phyclk),
         .phyreset_n      (phyreset_n),
         .link_up         (link_up[c]),
         .tx_data         (tx_data[32*c +: 32]),
         .tx_isk          (tx_isk[c]),
         .tx_pop          (tx_pop[c]),
         .gtx_txdata      (gtx_txdata[32*c +: 32]),
         .gtx_txcharisk   (gtx_txcharisk[4*c +: 4]),
         .gtx_rxdata      (gtx_rxdata[32*c +: 32]),
         .gtx_rxcharisk   (gtx_rxcharisk[4*c +: 4]),
         .rx_data         (rx_data[32*c +: 32]),
         .rx_isk          (rx_isk[c]),
         .rx_valid        (rx_valid[c]),
         .rx_aligned      (rx_aligned[c])
`ifdef SATA_PHY_IF_STATS_EN
         ,
         .stat_align_drop (stat_align_drop[16*c +: 16]),
         .stat_relock     (stat_relock[8*c +: 8])
`endif
      );
   end

endmodule

// File: tb/tb_sata_phy_if_mc.sv
// Directed bench for sata_phy_if_mc: 4 channels, ALIGN interval 16, channel 2 active.
module tb_sata_phy_if_mc;

   localparam int          N     = 4;
   localparam int          INTV  = 16;
   localparam int          CH    = 2;
   localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
   localparam logic [3:0]  AK    = 4'b0001;
   localparam logic [31:0] SYNC  = 32'hB5B5957C;
   localparam logic [31:0] D1    = 32'h12345678;
   localparam logic [31:0] D2    = 32'hCAFEF00D;

   logic              phyclk = 1'b0;
   logic              phyreset_n;
   logic [N-1:0]      link_up, tx_isk, tx_pop, rx_isk, rx_valid, rx_aligned;
   logic [N*32-1:0]   tx_data, gtx_txdata, gtx_rxdata, rx_data;
   logic [N*4-1:0]    gtx_txcharisk, gtx_rxcharisk;
`ifdef SATA_PHY_IF_STATS_EN
   logic [N*16-1:0]   stat_align_drop;
   logic [N*8-1:0]    stat_relock;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] xprev;
   logic [3:0]  xkprev;

   always #5 phyclk = ~phyclk;

   sata_phy_if_mc #(.C_NUM_CHAN(N), .C_ALIGN_INTERVAL(INTV)) dut (
      .phyclk        (phyclk),
      .phyreset_n    (phyreset_n),
      .link_up       (link_up),
      .tx_data       (tx_data),
      .tx_isk        (tx_isk),
      .tx_pop        (tx_pop),
      .gtx_txdata    (gtx_txdata),
      .gtx_txcharisk (gtx_txcharisk),
      .gtx_rxdata    (gtx_rxdata),
      .gtx_rxcharisk (gtx_rxcharisk),
      .rx_data       (rx_data),
      .rx_isk        (rx_isk),
      .rx_valid      (rx_valid),
      .rx_aligned    (rx_aligned)
`ifdef SATA_PHY_IF_STATS_EN
      ,
      .stat_align_drop (stat_align_drop),
      .stat_relock     (stat_relock)
`endif
   );

   task automatic tick;
      @(posedge phyclk);
      #1;
   endtask

   // Feed transmitted dword x through a channel rotated so its comma lands on lane p.
   task automatic rx_send(input logic [31:0] x, input logic [3:0] xk, input int p);
      logic [63:0] cat;
      logic [7:0]  kc;
      cat = {x, xprev} >> (32 - 8 * p);
      kc  = {xk, xkprev} >> (4 - p);
      gtx_rxdata[CH*32 +: 32]   = cat[31:0];
      gtx_rxcharisk[CH*4 +: 4]  = kc[3:0];
      xprev  = x;
      xkprev = xk;
      tick();
   endtask

   task automatic test_reset;
      phyreset_n = 1'b0;
      link_up = '0; tx_isk = '0; tx_data = '0; gtx_rxdata = '0; gtx_rxcharisk = '0;
      xprev = '0; xkprev = '0;
      #23;
      n_tests++;
      if (gtx_txdata !== {N{ALIGN}}) begin n_fail++; $display("FAIL reset_txdata: got %h want %h", gtx_txdata, {N{ALIGN}}); end
      n_tests++;
      if (gtx_txcharisk !== {N{AK}}) begin n_fail++; $display("FAIL reset_txk: got %h want %h", gtx_txcharisk, {N{AK}}); end
      n_tests++;
      if (tx_pop !== '0) begin n_fail++; $display("FAIL reset_pop: got %b want 0", tx_pop); end
      n_tests++;
      if ({rx_data, rx_isk, rx_valid, rx_aligned} !== '0) begin
         n_fail++; $display("FAIL reset_rx: data %h isk %b valid %b aligned %b want 0", rx_data, rx_isk, rx_valid, rx_aligned);
      end
      @(negedge phyclk);
      phyreset_n = 1'b1;
      tick(); tick();
      n_tests++;
      if (gtx_txdata[CH*32 +: 32] !== ALIGN || tx_pop !== '0) begin
         n_fail++; $display("FAIL linkdn_idle: got %h pop %b want %h pop 0", gtx_txdata[CH*32 +: 32], tx_pop, ALIGN);
      end
   endtask

   // Raise link_up on CH and check n_edges clocks of output against the ALIGN-pair period.
   task automatic tx_run(input int n_edges, input string name);
      logic [31:0] cnt, exp_d;
      logic        pop_b, exp_pop, others_ok;
      int          ph, pops_low;
      cnt = 32'd1;
      pops_low = 0;
      tx_data[CH*32 +: 32] = cnt;
      tx_isk[CH] = 1'b0;
      link_up[CH] = 1'b1;
      for (int k = 1; k <= n_edges; k++) begin
         pop_b = tx_pop[CH];
         tick();
         if (pop_b) begin
            cnt = cnt + 1;
            tx_data[CH*32 +: 32] = cnt;
         end
         if (k <= 3) exp_d = ALIGN;
         else begin
            ph = (k - 2) % INTV;
            exp_d = (ph < 2) ? ALIGN : 32'(((k - 2) / INTV) * (INTV - 2) + ph - 1);
         end
         n_tests++;
         if (gtx_txdata[CH*32 +: 32] !== exp_d) begin
            n_fail++; $display("FAIL %s_data k=%0d: got %h want %h", name, k, gtx_txdata[CH*32 +: 32], exp_d);
         end
         exp_pop = (k >= 3) && (((k - 1) % INTV) >= 2);
         n_tests++;
         if (tx_pop[CH] !== exp_pop) begin
            n_fail++; $display("FAIL %s_pop k=%0d: got %b want %b", name, k, tx_pop[CH], exp_pop);
         end
         if (k >= 3 && tx_pop[CH] === 1'b0) pops_low++;
         others_ok = 1'b1;
         for (int c = 0; c < N; c++) begin
            if (c != CH && (gtx_txdata[c*32 +: 32] !== ALIGN || gtx_txcharisk[c*4 +: 4] !== AK || tx_pop[c] !== 1'b0))
               others_ok = 1'b0;
         end
         n_tests++;
         if (!others_ok) begin
            n_fail++; $display("FAIL %s_idle_chans k=%0d: got data %h pop %b want ALIGN pop 0", name, k, gtx_txdata, tx_pop);
         end
      end
      n_tests++;
      if (pops_low != 4) begin n_fail++; $display("FAIL %s_pop_low_count: got %0d want 4", name, pops_low); end
   endtask

   task automatic wait_pop_rise(input string name);
      int t;
      t = 0;
      while (tx_pop[CH] !== 1'b0 && t < 40) begin tick(); t++; end
      while (tx_pop[CH] !== 1'b1 && t < 40) begin tick(); t++; end
      if (t >= 40) begin
         n_tests++; n_fail++;
         $display("FAIL %s_timeout: got no tx_pop rise want rise within 40 cycles", name);
      end
   endtask

   task automatic test_insertion_period;
      tx_run(34, "period");
   endtask

   task automatic test_k_flag;
      wait_pop_rise("kflag");
      tx_data[CH*32 +: 32] = SYNC;
      tx_isk[CH] = 1'b1;
      tick();
      n_tests++;
      if (gtx_txdata[CH*32 +: 32] !== SYNC || gtx_txcharisk[CH*4 +: 4] !== 4'b0001) begin
         n_fail++; $display("FAIL kflag_set: got %h/%b want %h/0001", gtx_txdata[CH*32 +: 32], gtx_txcharisk[CH*4 +: 4], SYNC);
      end
      tx_data[CH*32 +: 32] = 32'h0000_0011;
      tx_isk[CH] = 1'b0;
      tick();
      n_tests++;
      if (gtx_txdata[CH*32 +: 32] !== 32'h0000_0011 || gtx_txcharisk[CH*4 +: 4] !== 4'b0000) begin
         n_fail++; $display("FAIL kflag_clr: got %h/%b want 00000011/0000", gtx_txdata[CH*32 +: 32], gtx_txcharisk[CH*4 +: 4]);
      end
   endtask

   task automatic test_link_drop;
      wait_pop_rise("drop");
      for (int i = 0; i < 5; i++) tick();
      link_up[CH] = 1'b0;
      tick();
      n_tests++;
      if (tx_pop[CH] !== 1'b0 || rx_valid[CH] !== 1'b0) begin
         n_fail++; $display("FAIL drop_state: got pop %b rx_valid %b want 0 0", tx_pop[CH], rx_valid[CH]);
      end
      tick();
      n_tests++;
      if (gtx_txdata[CH*32 +: 32] !== ALIGN || gtx_txcharisk[CH*4 +: 4] !== AK) begin
         n_fail++; $display("FAIL drop_align: got %h/%b want %h/0001", gtx_txdata[CH*32 +: 32], gtx_txcharisk[CH*4 +: 4], ALIGN);
      end
      tx_run(34, "rerise");
   endtask

   task automatic test_lane_lock;
      rx_send(ALIGN, AK, 2);
      n_tests++;
      if (rx_aligned[CH] !== 1'b0) begin n_fail++; $display("FAIL lock_early0: got %b want 0", rx_aligned[CH]); end
      rx_send(ALIGN, AK, 2);
      n_tests++;
      if (rx_aligned[CH] !== 1'b0 || rx_valid[CH] !== 1'b0) begin
         n_fail++; $display("FAIL lock_early1: got aligned %b valid %b want 0 0", rx_aligned[CH], rx_valid[CH]);
      end
      rx_send(ALIGN, AK, 2);
      n_tests++;
      if (rx_aligned[CH] !== 1'b1 || rx_valid[CH] !== 1'b0) begin
         n_fail++; $display("FAIL lock_set: got aligned %b valid %b want 1 0", rx_aligned[CH], rx_valid[CH]);
      end
      rx_send(ALIGN, AK, 2);
      rx_send(D1, 4'b0000, 2);
      n_tests++;
      if (rx_valid[CH] !== 1'b0) begin n_fail++; $display("FAIL lock_align_drop: got valid %b want 0", rx_valid[CH]); end
      rx_send(D2, 4'b0000, 2);
      n_tests++;
      if (rx_valid[CH] !== 1'b1 || rx_data[CH*32 +: 32] !== D1 || rx_isk[CH] !== 1'b0) begin
         n_fail++; $display("FAIL lock_d1: got %h v%b k%b want %h v1 k0", rx_data[CH*32 +: 32], rx_valid[CH], rx_isk[CH], D1);
      end
      rx_send(SYNC, 4'b0001, 2);
      n_tests++;
      if (rx_valid[CH] !== 1'b1 || rx_data[CH*32 +: 32] !== D2) begin
         n_fail++; $display("FAIL lock_d2: got %h v%b want %h v1", rx_data[CH*32 +: 32], rx_valid[CH], D2);
      end
      rx_send(ALIGN, AK, 2);
      n_tests++;
      if (rx_valid[CH] !== 1'b1 || rx_data[CH*32 +: 32] !== SYNC || rx_isk[CH] !== 1'b1) begin
         n_fail++; $display("FAIL lock_sync: got %h v%b k%b want %h v1 k1", rx_data[CH*32 +: 32], rx_valid[CH], rx_isk[CH], SYNC);
      end
      rx_send(ALIGN, AK, 2);
      n_tests++;
      if (rx_valid[CH] !== 1'b0) begin n_fail++; $display("FAIL lock_tail_align: got valid %b want 0", rx_valid[CH]); end
`ifdef SATA_PHY_IF_STATS_EN
      n_tests++;
      if (stat_align_drop[CH*16 +: 16] !== 16'd5 || stat_relock[CH*8 +: 8] !== 8'd1) begin
         n_fail++; $display("FAIL lock_stats: got drop %0d relock %0d want 5 1", stat_align_drop[CH*16 +: 16], stat_relock[CH*8 +: 8]);
      end
`endif
   endtask

   task automatic test_relock;
      rx_send(ALIGN, AK, 2);
      n_tests++;
      if (rx_aligned[CH] !== 1'b1) begin n_fail++; $display("FAIL relock_pre: got %b want 1", rx_aligned[CH]); end
      rx_send(ALIGN, AK, 1);
      n_tests++;
      if (rx_aligned[CH] !== 1'b0) begin n_fail++; $display("FAIL relock_drop: got %b want 0", rx_aligned[CH]); end
      rx_send(ALIGN, AK, 1);
      n_tests++;
      if (rx_aligned[CH] !== 1'b0) begin n_fail++; $display("FAIL relock_one: got %b want 0", rx_aligned[CH]); end
      rx_send(ALIGN, AK, 1);
      n_tests++;
      if (rx_aligned[CH] !== 1'b1) begin n_fail++; $display("FAIL relock_set: got %b want 1", rx_aligned[CH]); end
      rx_send(D1, 4'b0000, 1);
      rx_send(ALIGN, AK, 1);
      n_tests++;
      if (rx_valid[CH] !== 1'b1 || rx_data[CH*32 +: 32] !== D1) begin
         n_fail++; $display("FAIL relock_data: got %h v%b want %h v1", rx_data[CH*32 +: 32], rx_valid[CH], D1);
      end
`ifdef SATA_PHY_IF_STATS_EN
      n_tests++;
      if (stat_relock[CH*8 +: 8] !== 8'd2) begin
         n_fail++; $display("FAIL relock_stat: got %0d want 2", stat_relock[CH*8 +: 8]);
      end
`endif
   endtask

   task automatic test_reset_mid;
      wait_pop_rise("midrst");
      tx_data[CH*32 +: 32] = 32'h0000_0055;
      tick();
      n_tests++;
      if (gtx_txdata[CH*32 +: 32] !== 32'h0000_0055 || rx_aligned[CH] !== 1'b1) begin
         n_fail++; $display("FAIL midrst_pre: got %h aligned %b want 00000055 1", gtx_txdata[CH*32 +: 32], rx_aligned[CH]);
      end
      #2;
      phyreset_n = 1'b0;
      #1;
      n_tests++;
      if (gtx_txdata[CH*32 +: 32] !== ALIGN || tx_pop[CH] !== 1'b0 || rx_aligned[CH] !== 1'b0 ||
          rx_valid[CH] !== 1'b0 || rx_data[CH*32 +: 32] !== 32'h0) begin
         n_fail++; $display("FAIL midrst_async: got tx %h pop %b aligned %b valid %b rx %h want ALIGN 0 0 0 0",
                            gtx_txdata[CH*32 +: 32], tx_pop[CH], rx_aligned[CH], rx_valid[CH], rx_data[CH*32 +: 32]);
      end
      link_up = '0;
      @(negedge phyclk);
      phyreset_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_insertion_period();
      test_k_flag();
      test_link_drop();
      test_lane_lock();
      test_relock();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sata_phy_if_mc.md
# sata_phy_if_mc

Multi-channel SATA PHY-interface adapter between the per-port link layers and the GTX/GTP transceiver dword ports, scaling to `C_NUM_CHAN` channels. Per channel, the TX path inserts ALIGN primitive pairs at a programmable interval and back-pressures the link layer with a pop strobe. The RX path locks byte-lane alignment on K28.5, drops received ALIGNs and delivers aligned dwords with a K flag. One instance replaces the per-port fixed adapters in the transceiver wrapper.

## Interface
- `C_NUM_CHAN`, 2: number of channels, 1..8.
- `C_ALIGN_INTERVAL`, 256: dwords per ALIGN period, including the ALIGN pair; range 8..1024.
- `phyclk` in 1: transceiver user clock, shared by all channels.
- `phyreset_n` in 1: reset, asynchronous active-low.
- `link_up` in N: per-channel OOB-complete.
- `tx_data` in N*32: link-layer TX dword; channel c occupies `[32c+31:32c]`.
- `tx_isk` in N: TX dword byte0 is a K character.
- `tx_pop` out N: TX dword consumed this cycle.
- `gtx_txdata` out N*32, `gtx_txcharisk` out N*4: to transceiver.
- `gtx_rxdata` in N*32, `gtx_rxcharisk` in N*4: from transceiver, unaligned.
- `rx_data` out N*32, `rx_isk` out N, `rx_valid` out N: aligned RX dword, ALIGNs removed.
- `rx_aligned` out N: lane lock achieved.

## Operation
- ALIGN is `32'h7B4A4ABC` with charisk `4'b0001`.
- **TX FSM, per channel.** States are LINKDN, ALN1, ALN2, DATA.
  - LINKDN: drive ALIGN continuously; `tx_pop`=0. Leave to ALN1 when `link_up`=1.
  - ALN1 → ALN2 → DATA: drive ALIGN in each; `tx_pop`=0.
  - DATA: pass `tx_data`; charisk = `{3'b0,tx_isk}`; `tx_pop`=1. Counter `dcnt` starts at 0 and advances once per DATA cycle.
  - When `dcnt`==`C_ALIGN_INTERVAL`-3 in DATA, the next state is ALN1 and `dcnt` clears. DATA therefore lasts exactly `C_ALIGN_INTERVAL`-2 cycles per period.
  - `link_up`=0 in any state → LINKDN on the next clock; `dcnt` clears.
- **RX lane aligner, per channel.**
  - `prev` register holds the last input dword and charisk.
  - Comma lane p = index of the one-hot set bit of the input charisk. An input that is not one-hot does not update the lane.
  - Aligned word = `{cur[8p-1:0], prev[31:8p]}`; p=0 yields `prev`. Charisk is rotated the same way.
  - Lane register `off` updates when a comma is seen at p≠`off`.
  - `rx_aligned` sets after two consecutive aligned ALIGNs at the same `off`. It clears on any `off` change or on `link_up`=0.
  - Output stage: an aligned ALIGN gives `rx_valid`=0. Any other word gives `rx_valid`=`rx_aligned`, with `rx_isk`=aligned charisk bit0.
  - `link_up`=0 forces `rx_valid`=0.
- Channels are fully independent; only the clock and reset are shared.

## Timing
- **Reset.**
  - TX: LINKDN, `dcnt`=0, `gtx_txdata`=ALIGN, `gtx_txcharisk`=`4'b0001`, `tx_pop`=0.
  - RX: `off`=0, `rx_data`=0, `rx_isk`=0, `rx_valid`=0, `rx_aligned`=0.
- **TX latency.** 1 cycle, registered outputs. The dword presented while `tx_pop`=1 appears on `gtx_txdata` on the next clock.
- **`tx_pop` timing.** `tx_pop` is combinational from the FSM state, not from the source. The source must present a new dword every cycle in which `tx_pop`=1.
- **RX latency.** 2 cycles from `gtx_rxdata` to `rx_data`: one cycle in `prev`, one in the output register.
- **`link_up` rise.** The first data dword reaches `gtx_txdata` exactly 4 clocks later (ALN1, ALN2, DATA, register).
- **Lane change.** A lane change at cycle t affects output t+2. That output word is built with the new `off`.
- **Simultaneous `link_up` fall and ALN1 entry.** LINKDN wins.
- **Reset mid-operation.** Reset returns all outputs to their reset values asynchronously.

## Configuration
- `SATA_PHY_IF_STATS_EN` defined: adds outputs, per channel:
  - `stat_align_drop` N*16: saturating count of dropped RX ALIGNs.
  - `stat_relock` N*8: saturating count of `off` changes.
  - Both counters clear on reset and on `link_up` rise.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package `sata_phy_pkg` holds:
  - `SATA_ALIGN` = `32'h7B4A4ABC` and `SATA_ALIGN_K` = `4'b0001`.
  - The TX state enum `tx_state_t`.
  - The function `comma_lane` (one-hot charisk → lane index plus valid flag).
- Sub-module `sata_phy_lane` holds one channel (TX FSM plus RX aligner plus optional stats). The top is a generate loop with bus slicing.

## Test plan
1. **Insertion period.** `C_ALIGN_INTERVAL`=16, `link_up`=1 held, `tx_data` counting from 1.
   - Required: `gtx_txdata` repeats the pattern ALIGN, ALIGN, then 14 consecutive data dwords 1..14.
   - Required: `tx_pop` is low exactly 2 of every 16 cycles.
2. **K flag.** `tx_isk`=1 with `tx_data`=`32'hB5B5957C` (SYNC).
   - Required: `gtx_txcharisk`=`4'b0001` one cycle later.
   - With `tx_isk`=0, required: `4'b0000`.
3. **Lane lock.** RX stream of ALIGN rotated by 2 bytes (`32'h4ABC7B4A` repeated, charisk `4'b0100`), then a data word.
   - Required: `off`=2 and `rx_aligned`=1 after the 2nd aligned ALIGN.
   - Required: ALIGNs give `rx_valid`=0; the data word appears correctly de-rotated with `rx_valid`=1.
4. **Relock.** After lock at `off`=2, inject a comma at lane 1.
   - Required: `rx_aligned` drops.
   - Required: it re-asserts after two ALIGNs at lane 1.
   - With stats enabled, required: `stat_relock` increments by 1.
5. **Link drop mid-period.** `link_up` falls at DATA `dcnt`=5.
   - Required: the next clock's TX state is LINKDN, so ALIGN is output.
   - Required: `rx_valid`=0.
   - On `link_up` re-rise, required: the ALIGN pair precedes data and `dcnt` restarts at 0.
6. **Channel independence.** `C_NUM_CHAN`=4 with only channel 2 link-up.
   - Required: channels 0, 1 and 3 output continuous ALIGN with `tx_pop`=0.
   - Required: channel 2 behaves as in scenario 1.
